digit_scan_ctrl: RTL and testbench



---
 rtl/digit_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment display with double-buffered digit data.
// Define SEG_SCAN_BLANK_EN to insert an anti-ghosting blank gap after every digit slot.
module digit_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] data,
  input  logic        load,
  output logic [2:0]  sel,
  output logic [6:0]  seg,
  output logic        digit_valid,
  output logic        wrap
);

`ifdef SEG_SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int PW      = $clog2(CNT_MAX);
  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
`ifdef SEG_SCAN_BLANK_EN
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
`endif
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic [31:0]   pending;
  logic [31:0]   display;

  logic [2:0]  adv_sel;
  logic        adv_wrap;
  logic [31:0] adv_display;
  logic [6:0]  adv_seg;
  logic [6:0]  first_seg;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Next slot: the display swap happens on the same edge as the wrap so the
  // registered segment pattern already reflects the new frame's data.
  assign adv_wrap    = (sel == LAST_IDX);
  assign adv_sel     = adv_wrap ? 3'd0 : sel + 3'd1;
  assign adv_display = adv_wrap ? (load ? data : pending) : display;
  assign adv_seg     = hex_to_seg(adv_display[{adv_sel, 2'b00} +: 4]);
  assign first_seg   = hex_to_seg(display[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      presc       <= '0;
      pending     <= '0;
      display     <= '0;
      sel         <= 3'd0;
      seg         <= 7'h00;
      digit_valid <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      if (load)
        pending <= data;
      wrap <= 1'b0;
      if (!en) begin
        state       <= IDLE;
        presc       <= '0;
        seg         <= 7'h00;
        digit_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state       <= SHOW;
            presc       <= '0;
            sel         <= 3'd0;
            seg         <= first_seg;
            digit_valid <= 1'b1;
          end
          SHOW: begin
            if (presc == DIV_LAST) begin
              presc <= '0;
`ifdef SEG_SCAN_BLANK_EN
              state       <= BLANK;
              seg         <= 7'h00;
              digit_valid <= 1'b0;
`else
              sel         <= adv_sel;
              seg         <= adv_seg;
              wrap        <= adv_wrap;
              display     <= adv_display;
              digit_valid <= 1'b1;
`endif
            end else begin
              presc <= presc + 1'b1;
            end
          end
`ifdef SEG_SCAN_BLANK_EN
          BLANK: begin
            if (presc == BLANK_LAST) begin
              presc       <= '0;
              state       <= SHOW;
              sel         <= adv_sel;
              seg         <= adv_seg;
              wrap        <= adv_wrap;
              display     <= adv_display;
              digit_valid <= 1'b1;
            end else begin
              presc <= presc + 1'b1;
            end
          end
`endif
          default: begin
            state       <= IDLE;
            presc       <= '0;
            seg         <= 7'h00;
            digit_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl: directed scenarios plus random traffic
// against a timeline model (slot = cycles since enable divided by slot length).
module tb_digit_scan_ctrl;

  localparam int CLK_DIV      = 4;
  localparam int NUM_DIGITS   = 8;
  localparam int BLANK_CYCLES = 2;
`ifdef SEG_SCAN_BLANK_EN
  localparam int BLANK_LEN = BLANK_CYCLES;
`else
  localparam int BLANK_LEN = 0;
`endif
  localparam int SLOT  = CLK_DIV + BLANK_LEN;
  localparam int FRAME = NUM_DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [31:0] data = 32'h0;
  logic        load = 1'b0;
  logic [2:0]  sel;
  logic [6:0]  seg;
  logic        digit_valid;
  logic        wrap;

  digit_scan_ctrl #(
    .CLK_DIV(CLK_DIV),
    .NUM_DIGITS(NUM_DIGITS),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .data(data),
    .load(load),
    .sel(sel),
    .seg(seg),
    .digit_valid(digit_valid),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0]  seg_tbl [16];
  bit          m_active;
  int          m_t;
  logic [31:0] m_pending;
  logic [31:0] m_display;
  logic [2:0]  e_sel;
  logic [6:0]  e_seg;
  logic        e_valid;
  logic        e_wrap;
  string       phase;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_active  = 0;
    m_t       = 0;
    m_pending = 32'h0;
    m_display = 32'h0;
    e_sel     = 3'd0;
    e_seg     = 7'h00;
    e_valid   = 1'b0;
    e_wrap    = 1'b0;
  endtask

  // One clock edge of the reference: position in the scan timeline since enable.
  task automatic modelEdge(input logic en_v, input logic load_v, input logic [31:0] data_v);
    if (load_v)
      m_pending = data_v;
    if (!en_v) begin
      m_active = 0;
      e_valid  = 1'b0;
      e_seg    = 7'h00;
      e_wrap   = 1'b0;
    end else begin
      if (m_active) begin
        m_t++;
      end else begin
        m_active = 1;
        m_t      = 0;
      end
      e_wrap = (m_t > 0) && (m_t % FRAME == 0);
      if (e_wrap)
        m_display = m_pending;
      e_sel   = 3'((m_t / SLOT) % NUM_DIGITS);
      e_valid = (m_t % SLOT) < CLK_DIV;
      e_seg   = e_valid ? seg_tbl[4'(m_display >> (4 * int'(e_sel)))] : 7'h00;
    end
  endtask

  task automatic checkAll();
    checkOutput({phase, ".sel"}, 32'(sel), 32'(e_sel));
    checkOutput({phase, ".seg"}, 32'(seg), 32'(e_seg));
    checkOutput({phase, ".valid"}, 32'(digit_valid), 32'(e_valid));
    checkOutput({phase, ".wrap"}, 32'(wrap), 32'(e_wrap));
  endtask

  task automatic applyStimulus(input logic en_v, input logic load_v, input logic [31:0] data_v);
    en   = en_v;
    load = load_v;
    data = data_v;
    @(posedge clk);
    modelEdge(en_v, load_v, data_v);
    #1;
    checkAll();
    @(negedge clk);
  endtask

  task automatic idleRun(input int n, input logic en_v);
    for (int i = 0; i < n; i++)
      applyStimulus(en_v, 1'b0, 32'h0);
  endtask

  // Step until the model predicts the given index at the given phase within its slot.
  task automatic runToSlot(input int idx, input int ph);
    bit hit = 0;
    for (int i = 0; i < 4 * FRAME && !hit; i++) begin
      if (m_active && int'(e_sel) == idx && (m_t % SLOT) == ph)
        hit = 1;
      else
        applyStimulus(1'b1, 1'b0, 32'h0);
    end
    if (!hit)
      checkOutput({phase, ".reach_slot"}, 32'd0, 32'd1);
  endtask

  task automatic asyncReset();
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    modelReset();

    phase = "reset";
    #1 rst_n = 1'b0;
    #1 checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    phase = "enable";
    idleRun(10, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("enable.first_seg", 32'(seg), 32'h3F);

    phase = "frame";
    applyStimulus(1'b1, 1'b1, 32'hFEDCBA98);
    while (!e_wrap && m_t < 2 * FRAME)
      applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("frame.wrap_seg", 32'(seg), 32'h7F);
    idleRun(2 * FRAME, 1'b1);

    phase = "tear";
    runToSlot(3, 1);
    applyStimulus(1'b1, 1'b1, 32'h11111111);
    runToSlot(5, 1);
    applyStimulus(1'b1, 1'b1, 32'h22222222);
    while (!e_wrap && m_t < 4 * FRAME)
      applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("tear.wrap_seg", 32'(seg), 32'h5B);
    idleRun(FRAME, 1'b1);

    phase = "coincide";
    for (int i = 0; i < 2 * FRAME && ((m_t + 1) % FRAME) != 0; i++)
      applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h00000007);
    checkOutput("coincide.wrap", 32'(wrap), 32'd1);
    checkOutput("coincide.seg", 32'(seg), 32'h07);
    idleRun(SLOT, 1'b1);

    phase = "endrop";
    runToSlot(4, 2);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("endrop.valid", 32'(digit_valid), 32'd0);
    idleRun(3, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("endrop.restart_sel", 32'(sel), 32'd0);
    runToSlot(7, CLK_DIV - 1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    idleRun(2, 1'b1);

    phase = "midreset";
    runToSlot(2, 1);
    asyncReset();
    idleRun(3, 1'b0);
    idleRun(FRAME + 3, 1'b1);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      if (i == 777) begin
        asyncReset();
      end else begin
        applyStimulus(($urandom_range(63) != 0), ($urandom_range(7) == 0), $urandom());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
